// File: rtl/vga_pkg.sv
// Shared types and sizing for the VGA raster timing block.
// Both axes walk SYNC -> BACKPORCH -> VISIBLE -> FRONTPORCH.
package vga_pkg;

  localparam int TB_WIDTH     = 10;
  localparam int VB_WIDTH     = 16;
  localparam int TIMCNT_WIDTH = 12;

  typedef enum logic [1:0] {
    BACKPORCH  = 2'b00,
    VISIBLE    = 2'b01,
    FRONTPORCH = 2'b10,
    SYNC       = 2'b11
  } tim_state_e;

  typedef struct packed {
    logic [TB_WIDTH-1:0] fp;
    logic [TB_WIDTH-1:0] sn;
    logic [TB_WIDTH-1:0] bp;
    logic [VB_WIDTH-1:0] vis;
  } axis_cfg_t;

  // Terminal count for a field: a zero field lasts one unit, and lengths
  // beyond the counter range saturate so the counter never has to wrap.
  function automatic logic [TIMCNT_WIDTH-1:0] last_cnt(input logic [VB_WIDTH-1:0] f);
    if (f == '0) return '0;
    if (f[VB_WIDTH-1:TIMCNT_WIDTH] != '0) return '1;
    return f[TIMCNT_WIDTH-1:0] - TIMCNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/vga_tim_axis.sv
// One raster axis: state FSM plus per-state counter. 'adv' steps the axis by
// one unit; 'wrap' flags the step that leaves FRONTPORCH (end of line/frame).
module vga_tim_axis
  import vga_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    adv,
  input  axis_cfg_t               cfg,
  output tim_state_e              state,
  output logic [TIMCNT_WIDTH-1:0] cnt,
  output logic                    wrap
);

  logic [TIMCNT_WIDTH-1:0] last;
  tim_state_e              next_state;

  always_comb begin
    last       = '0;
    next_state = SYNC;
    unique case (state)
      SYNC:       begin last = last_cnt(VB_WIDTH'(cfg.sn)); next_state = BACKPORCH;  end
      BACKPORCH:  begin last = last_cnt(VB_WIDTH'(cfg.bp)); next_state = VISIBLE;    end
      VISIBLE:    begin last = last_cnt(cfg.vis);           next_state = FRONTPORCH; end
      FRONTPORCH: begin last = last_cnt(VB_WIDTH'(cfg.fp)); next_state = SYNC;       end
      default:    begin last = '0;                          next_state = SYNC;       end
    endcase
  end

  assign wrap = adv && (state == FRONTPORCH) && (cnt == last);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= SYNC;
      cnt   <= '0;
    end else if (adv) begin
      if (cnt == last) begin
        state <= next_state;
        cnt   <= '0;
      end else begin
        cnt <= cnt + TIMCNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster timing controller: H axis steps on pixel ticks, V axis on H wrap.
// Holds the per-frame config shadow and the registered, polarity-adjusted outputs.
module vga_timing_ctrl
  import vga_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                pix_tick_i,
  input  logic [TB_WIDTH-1:0] h_fp_i,
  input  logic [TB_WIDTH-1:0] h_sn_i,
  input  logic [TB_WIDTH-1:0] h_bp_i,
  input  logic [TB_WIDTH-1:0] v_fp_i,
  input  logic [TB_WIDTH-1:0] v_sn_i,
  input  logic [TB_WIDTH-1:0] v_bp_i,
  input  logic [VB_WIDTH-1:0] h_vis_i,
  input  logic [VB_WIDTH-1:0] v_vis_i,
  input  logic                hspol_i,
  input  logic                vspol_i,
  input  logic                blpol_i,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic                de_o,
  output logic [VB_WIDTH-1:0] pix_x_o,
  output logic [VB_WIDTH-1:0] pix_y_o,
  output logic                line_end_o,
  output logic                frame_end_o
);

  axis_cfg_t               h_cfg, v_cfg;
  tim_state_e              h_state, v_state;
  logic [TIMCNT_WIDTH-1:0] h_cnt, v_cnt;
  logic                    h_adv, h_wrap, v_wrap;

  assign h_adv = pix_tick_i && en_i && !rst_i;

  vga_tim_axis u_h_axis (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (!en_i),
    .adv   (h_adv),
    .cfg   (h_cfg),
    .state (h_state),
    .cnt   (h_cnt),
    .wrap  (h_wrap)
  );

  vga_tim_axis u_v_axis (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (!en_i),
    .adv   (h_wrap),
    .cfg   (v_cfg),
    .state (v_state),
    .cnt   (v_cnt),
    .wrap  (v_wrap)
  );

  // Shadow tracks the inputs while idle, so leaving idle starts from fresh config.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i || v_wrap) begin
      h_cfg <= '{fp: h_fp_i, sn: h_sn_i, bp: h_bp_i, vis: h_vis_i};
      v_cfg <= '{fp: v_fp_i, sn: v_sn_i, bp: v_bp_i, vis: v_vis_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hsync_o     <= 1'b0;
      vsync_o     <= 1'b0;
      de_o        <= 1'b0;
      pix_x_o     <= '0;
      pix_y_o     <= '0;
      line_end_o  <= 1'b0;
      frame_end_o <= 1'b0;
    end else if (!en_i) begin
      hsync_o     <= !hspol_i;
      vsync_o     <= !vspol_i;
      de_o        <= blpol_i;
      pix_x_o     <= '0;
      pix_y_o     <= '0;
      line_end_o  <= 1'b0;
      frame_end_o <= 1'b0;
    end else begin
      hsync_o     <= (h_state == SYNC) ~^ hspol_i;
      vsync_o     <= (v_state == SYNC) ~^ vspol_i;
      de_o        <= ((h_state == VISIBLE) && (v_state == VISIBLE)) ^ blpol_i;
      pix_x_o     <= (h_state == VISIBLE) ? VB_WIDTH'(h_cnt) : '0;
      pix_y_o     <= (v_state == VISIBLE) ? VB_WIDTH'(v_cnt) : '0;
      line_end_o  <= h_wrap;
      frame_end_o <= v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: per-cycle comparison against a position-based raster
// model, a table of timing scenarios, and hand-written enable/reset/shadow sequences.
module tb_vga_timing_ctrl;
  import vga_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, en, pix_tick;
  logic [TB_WIDTH-1:0] h_fp, h_sn, h_bp, v_fp, v_sn, v_bp;
  logic [VB_WIDTH-1:0] h_vis, v_vis;
  logic                hspol, vspol, blpol;
  logic                hsync, vsync, de, line_end, frame_end;
  logic [VB_WIDTH-1:0] pix_x, pix_y;

  vga_timing_ctrl dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pix_tick_i(pix_tick),
    .h_fp_i(h_fp), .h_sn_i(h_sn), .h_bp_i(h_bp),
    .v_fp_i(v_fp), .v_sn_i(v_sn), .v_bp_i(v_bp),
    .h_vis_i(h_vis), .v_vis_i(v_vis),
    .hspol_i(hspol), .vspol_i(vspol), .blpol_i(blpol),
    .hsync_o(hsync), .vsync_o(vsync), .de_o(de),
    .pix_x_o(pix_x), .pix_y_o(pix_y),
    .line_end_o(line_end), .frame_end_o(frame_end)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ticks   = 0;

  // ---------------- reference model ----------------
  // Raster position: tick index within the line and line index within the frame.
  // Segment lengths in order sync, backporch, visible, frontporch.
  int m_hpos, m_vline;
  int hl[4];
  int vl[4];

  function automatic int eff(input int f);
    int l;
    l = (f < 1) ? 1 : f;
    return (l > 4096) ? 4096 : l;
  endfunction

  task automatic load_cfg();
    hl[0] = eff(int'(h_sn)); hl[1] = eff(int'(h_bp)); hl[2] = eff(int'(h_vis)); hl[3] = eff(int'(h_fp));
    vl[0] = eff(int'(v_sn)); vl[1] = eff(int'(v_bp)); vl[2] = eff(int'(v_vis)); vl[3] = eff(int'(v_fp));
  endtask

  function automatic void locate(input int pos, input int l0, input int l1, input int l2,
                                 output int r, output int off);
    if (pos < l0)                begin r = 0; off = pos;           end
    else if (pos < l0 + l1)      begin r = 1; off = pos - l0;      end
    else if (pos < l0 + l1 + l2) begin r = 2; off = pos - l0 - l1; end
    else                         begin r = 3; off = pos - l0 - l1 - l2; end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: apply tick, let the edge happen, predict, then compare just after.
  task automatic cycle(input bit tick);
    logic [36:0] exp;
    int hr, ho, vr, vo, hsum, vsum;
    logic le, fe;
    pix_tick = tick;
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp = '0;
      m_hpos = 0; m_vline = 0; ticks = 0;
      load_cfg();
    end else if (!en) begin
      exp = {~hspol, ~vspol, blpol, 2'b00, 32'h0};
      m_hpos = 0; m_vline = 0; ticks = 0;
      load_cfg();
    end else begin
      locate(m_hpos, hl[0], hl[1], hl[2], hr, ho);
      locate(m_vline, vl[0], vl[1], vl[2], vr, vo);
      hsum = hl[0] + hl[1] + hl[2] + hl[3];
      vsum = vl[0] + vl[1] + vl[2] + vl[3];
      le = tick && (m_hpos == hsum - 1);
      fe = le && (m_vline == vsum - 1);
      exp = {(hr == 0) ~^ hspol, (vr == 0) ~^ vspol, (hr == 2 && vr == 2) ^ blpol, le, fe,
             (hr == 2) ? 16'(ho) : 16'h0, (vr == 2) ? 16'(vo) : 16'h0};
      if (tick) begin
        ticks++;
        m_hpos++;
        if (m_hpos == hsum) begin
          m_hpos = 0;
          m_vline++;
          if (m_vline == vsum) begin
            m_vline = 0;
            load_cfg();
          end
        end
      end
    end
    #1;
    check("outputs", {hsync, vsync, de, line_end, frame_end, pix_x, pix_y}, exp);
  endtask

  task automatic set_cfg(input int hf, input int hs, input int hb, input int hv,
                         input int vf, input int vs, input int vb, input int vv);
    h_fp = TB_WIDTH'(hf); h_sn = TB_WIDTH'(hs); h_bp = TB_WIDTH'(hb); h_vis = VB_WIDTH'(hv);
    v_fp = TB_WIDTH'(vf); v_sn = TB_WIDTH'(vs); v_bp = TB_WIDTH'(vb); v_vis = VB_WIDTH'(vv);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0);
    cycle(1'b1);
    rst = 1'b0;
    en  = 1'b1;
  endtask

  // Run with a tick every cycle until a frame_end or line_end pulse, bounded.
  task automatic run_until(input bit want_frame, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      cycle(1'b1);
      if (want_frame ? frame_end : line_end) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check_int(want_frame ? "frame_end_timeout" : "line_end_timeout", 0, 1);
  endtask

  // ---------------- timing table ----------------
  typedef struct {
    int hf, hs, hb, hv, vf, vs, vb, vv;
    bit hp, vp, bp;
    int period;
    int exp_line, exp_frame, exp_ticks, exp_de, exp_max_x;
  } row_t;

  row_t rows[7];

  task automatic run_row(input int idx, input row_t r);
    int fe_n, fe1, fe2, first_ticks, de_cnt, max_x, k;
    int line_q[$];
    set_cfg(r.hf, r.hs, r.hb, r.hv, r.vf, r.vs, r.vb, r.vv);
    hspol = r.hp; vspol = r.vp; blpol = r.bp;
    do_reset();
    fe_n = 0; fe1 = 0; fe2 = 0; first_ticks = -1; de_cnt = 0; max_x = 0; k = 0;
    while (fe_n < 2 && k < 3 * r.exp_frame + 100) begin
      cycle((k % r.period) == r.period - 1);
      k++;
      if (fe_n == 1) begin
        if (de != blpol) de_cnt++;
        if (int'(pix_x) > max_x) max_x = int'(pix_x);
      end
      if (frame_end) begin
        fe_n++;
        if (fe_n == 1) begin fe1 = cyc; first_ticks = ticks; end
        else fe2 = cyc;
      end else if (fe_n == 1 && line_end) begin
        line_q.push_back(cyc);
      end
    end
    if (fe_n < 2) begin
      check_int($sformatf("row%0d_timeout", idx), fe_n, 2);
    end else begin
      check_int($sformatf("row%0d_first_frame_ticks", idx), first_ticks, r.exp_ticks);
      check_int($sformatf("row%0d_frame_period", idx), fe2 - fe1, r.exp_frame);
      check_int($sformatf("row%0d_line_period", idx),
                (line_q.size() >= 2) ? line_q[1] - line_q[0] : -1, r.exp_line);
      check_int($sformatf("row%0d_de_cycles", idx), de_cnt, r.exp_de);
      check_int($sformatf("row%0d_max_pix_x", idx), max_x, r.exp_max_x);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    int at, at2, at3;
    rst = 1'b1; en = 1'b0; pix_tick = 1'b0;
    hspol = 1'b1; vspol = 1'b1; blpol = 1'b0;
    set_cfg(2, 3, 4, 8, 1, 2, 1, 4);
    load_cfg(); m_hpos = 0; m_vline = 0;

    //                hf hs hb  hv   vf vs vb vv  hp vp bp  p  line  frame  ticks  de    maxx
    rows[0] = '{2, 3, 4, 8,    1, 2, 1, 4, 1, 1, 0, 1, 17,   136,   136,   32,   7};
    rows[1] = '{2, 3, 4, 8,    1, 2, 1, 4, 1, 1, 0, 4, 68,   544,   136,   128,  7};
    rows[2] = '{2, 0, 4, 8,    1, 2, 0, 4, 1, 1, 0, 1, 15,   120,   120,   32,   7};
    rows[3] = '{2, 3, 4, 8,    1, 2, 1, 4, 0, 0, 1, 1, 17,   136,   136,   32,   7};
    rows[4] = '{0, 0, 0, 0,    0, 0, 0, 0, 1, 0, 0, 1, 4,    16,    16,    1,    0};
    rows[5] = '{1, 1, 1, 2,    0, 1, 1, 3, 0, 1, 1, 2, 10,   60,    30,    12,   1};
    rows[6] = '{0, 0, 0, 5000, 0, 0, 0, 0, 1, 1, 0, 1, 4099, 16396, 16396, 4096, 4095};

    foreach (rows[i]) run_row(i, rows[i]);

    // Mid-frame h_vis change: current frame keeps 8 pixels, next one uses 16.
    set_cfg(2, 3, 4, 8, 1, 2, 1, 4);
    hspol = 1'b1; vspol = 1'b1; blpol = 1'b0;
    do_reset();
    run_until(1'b1, 400, at);
    for (int i = 0; i < 20; i++) cycle(1'b1);
    h_vis = 16'd16;
    run_until(1'b0, 100, at);
    run_until(1'b0, 100, at2);
    check_int("shadow_old_line", at2 - at, 17);
    run_until(1'b1, 400, at);
    run_until(1'b0, 100, at2);
    run_until(1'b0, 100, at3);
    check_int("shadow_new_line", at3 - at2, 25);
    check_int("shadow_first_line_after_swap", at2 - at, 25);

    // en_i dropped mid-visible, re-raised after 5 cycles.
    set_cfg(2, 3, 4, 8, 1, 2, 1, 4);
    hspol = 1'b0; vspol = 1'b1; blpol = 1'b1;
    do_reset();
    at = -1;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1);
      if (de != blpol && pix_y == 16'd1 && pix_x == 16'd3) begin at = cyc; break; end
    end
    check_int("reach_visible", (at >= 0) ? 1 : 0, 1);
    en = 1'b0;
    cycle(1'b1);
    check("idle_levels", {hsync, vsync, de, line_end, frame_end, pix_x, pix_y},
          {1'b1, 1'b0, 1'b1, 2'b00, 32'h0});
    for (int i = 0; i < 4; i++) cycle(1'b1);
    en = 1'b1;
    run_until(1'b1, 400, at);
    check_int("reenable_frame_ticks", ticks, 136);

    // Reset mid-frame.
    for (int i = 0; i < 50; i++) cycle(1'b1);
    rst = 1'b1;
    cycle(1'b1);
    check("reset_zero", {hsync, vsync, de, line_end, frame_end, pix_x, pix_y}, 37'h0);
    rst = 1'b0;
    run_until(1'b1, 400, at);
    check_int("rst_frame_ticks", ticks, 136);

    // Randomized traffic: sparse ticks, mid-frame config changes, polarity flips,
    // occasional disable and reset pulses; model checks every cycle.
    set_cfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 9),
            $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 4));
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 149) == 0)
        set_cfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 9),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 4));
      if ($urandom_range(0, 299) == 0) begin
        hspol = 1'($urandom_range(0, 1));
        vspol = 1'($urandom_range(0, 1));
        blpol = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 599) == 0) en = ~en;
      else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
      rst = ($urandom_range(0, 999) == 0);
      cycle($urandom_range(0, 2) != 0);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
